tetris_board_store: RTL and testbench
=====================================

# tetris_board_store

Game-side board memory for the Tetris core: holds the committed cell map, answers the display's per-pixel scene queries with committed/moving-cell flags, and performs piece commit, full-row clearing and BCD score counting. It is the responder for the display's `scene_x`/`scene_y` → `cm`/`mm` lookup, and it feeds the 4-digit score shown by the display. Piece movement and rotation logic sits upstream and uses `collide_o` to validate candidate positions before moving.

## Interface
- `scene_width_p`, default 10: board width in cells.
- `scene_height_p`, default 20: board height in cells; row 0 is the top.
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  synchronous, active-high reset.
- One clock; reset is synchronous and active-high.
- `scene_x_i`  in  $clog2(scene_width_p)  display query column.
- `scene_y_i`  in  $clog2(scene_height_p)  display query row.
- `cm_o`  out  1  queried cell is committed.
- `mm_o`  out  1  queried cell is covered by the live piece.
- `piece_v_i`  in  1  live piece present.
- `piece_x_i`  in  6, signed  piece origin column.
- `piece_y_i`  in  6, signed  piece origin row.
- `piece_shape_i`  in  [3:0][3:0]  shape bitmap; bit `[dx][dy]` covers cell (x+dx, y+dy).
- `collide_o`  out  1  the piece at the current inputs overlaps a committed cell or lies out of bounds.
- `commit_v_i`  in  1  request to commit the piece.
- `commit_ready_o`  out  1  commit accepted when both are high.
- `clear_i`  in  1  synchronous game restart.
- `busy_o`  out  1  FSM not IDLE.
- `done_o`  out  1  one-cycle pulse at the end of commit processing.
- `lines_o`  out  3  rows cleared by the last commit (0–4).
- `score_o`  out  [3:0][3:0]  BCD score; `[0]` is the most significant digit.

## Operation
- **Storage:** `scene_height_p` × `scene_width_p` flop array `map`.
- **Display query (combinational):**
  - `cm_o = map[y][x]`.
  - `mm_o` = `piece_v_i` & `!busy_o` & some set shape bit maps onto (x, y).
  - A query with x ≥ width or y ≥ height returns 0 on both outputs.
- **Collision (combinational):** `collide_o` = 1 if any set shape bit maps to a cell where:
  - x < 0, x ≥ width, or y ≥ height; or
  - the cell is in range with y ≥ 0 and `map` is set there.
  - Cells with y < 0 never collide.
  - `collide_o` = 0 when `piece_v_i` = 0.
- **Handshake:** `commit_ready_o = (state==IDLE) & !clear_i`. A commit request while busy is ignored, not queued. The caller guarantees `collide_o` = 0 at commit; the block does not check.
- **FSM states:** IDLE, COMMIT, SCAN, SHIFT.
- **IDLE → COMMIT** on handshake:
  - Latch the piece x, y and shape.
  - Clear the line counter.
- **COMMIT:**
  - OR the latched in-range cells into `map`; cells with y < 0 are dropped.
  - Set `row` = height−1, go to SCAN.
- **SCAN:**
  - If `map[row]` is all ones, go to SHIFT.
  - Else if `row` == 0, go to IDLE and pulse `done_o`.
  - Else decrement `row` and stay in SCAN.
- **SHIFT (one cycle):**
  - `map[r] ← map[r−1]` for r = `row` down to 1; `map[0] ← 0`.
  - Increment `lines_o` and the score; return to SCAN at the same `row`.
- **Score:** 4-digit BCD, +1 per cleared row, with carry across digits. Saturates at 9999 and does not wrap.
- **`clear_i`:**
  - Zeroes `map`, `score_o` and `lines_o`; state → IDLE.
  - Aborts any in-progress commit with no `done_o`.
  - Priority: `reset_i` > `clear_i` > handshake.

## Timing
- **Reset values:** `map` = 0, state IDLE, `score_o` = 0000, `lines_o` = 0, `done_o` = 0, `busy_o` = 0, `commit_ready_o` = 1.
- **Combinational outputs:** `cm_o`, `mm_o` and `collide_o` settle in the same cycle as their inputs; there is no registered latency on the display path.
- **Commit timing:**
  - Handshake at cycle T; COMMIT at T+1; SCAN starts at T+2.
  - No full rows: SCAN runs T+2..T+1+height; `done_o` is high at T+2+height, in IDLE.
  - Each cleared row adds 2 cycles (SHIFT + rescan). With k cleared rows, `done_o` is at T+2+height+2k.
- **Status outputs:** `busy_o` is high from T+1 through the last SCAN cycle. `lines_o` and `score_o` update at the end of each SHIFT cycle. `lines_o` holds its value until the next handshake.
- **Back-to-back commits:** a new commit may be accepted in the `done_o` cycle.

## Test plan
- **Reset and query:** reset, then query every cell → `cm_o` = 0 everywhere, `score_o` = 0000, `commit_ready_o` = 1.
- **Collision bounds:** width 10, O-piece (bits [0][0],[0][1],[1][0],[1][1]):
  - at (8, 18) → `collide_o` = 0;
  - at (9, 18) → 1;
  - at (8, 19) → 1;
  - at (−1, 0) → 1;
  - at (3, −2) → 0.
- **Single-row clear:** fill row 19 columns 0–8, commit a vertical I-piece at x = 9 covering rows 16–19:
  - `done_o` at T+24;
  - `lines_o` = 1, `score_o` = 0001;
  - row 19 now holds the old row 18, with only column 9 set.
- **Four-row clear:** fill rows 16–19 except column 0, commit an I-piece at column 0:
  - `lines_o` = 4;
  - `done_o` at T+30;
  - `map` all zero.
- **Busy and display masking:** raise `commit_v_i` while busy → ignored, `commit_ready_o` = 0. With `piece_v_i` = 1, `mm_o` = 0 while busy.
- **Saturation and abort:** preload score to 9998 and clear 3 rows → score 9999. Assert `clear_i` mid-SCAN → next cycle IDLE, `map` = 0, `score_o` = 0000, and no `done_o` pulse.

Source files
------------

// File: rtl/tetris_board_store.sv
// Board store: committed cell map, 0-cycle scene/collision lookups, commit -> row-clear FSM with BCD score.
// Commit takes height+2+2k cycles to done_o; commit requests offered while busy are dropped, never queued.
module tetris_board_store #(
    parameter int scene_width_p  = 10,
    parameter int scene_height_p = 20
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [$clog2(scene_width_p)-1:0]  scene_x_i,
    input  logic [$clog2(scene_height_p)-1:0] scene_y_i,
    output logic                              cm_o,
    output logic                              mm_o,
    input  logic                              piece_v_i,
    input  logic signed [5:0]                 piece_x_i,
    input  logic signed [5:0]                 piece_y_i,
    input  logic [3:0][3:0]                   piece_shape_i,
    output logic                              collide_o,
    input  logic                              commit_v_i,
    output logic                              commit_ready_o,
    input  logic                              clear_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [2:0]                        lines_o,
    output logic [3:0][3:0]                   score_o
);

    localparam int xw_lp = $clog2(scene_width_p);
    localparam int yw_lp = $clog2(scene_height_p);

    typedef enum logic [1:0] {IDLE, COMMIT, SCAN, SHIFT} state_e;

    state_e                   state_q, state_d;
    logic [scene_width_p-1:0] map_q [scene_height_p];
    logic [scene_width_p-1:0] map_d [scene_height_p];
    logic signed [5:0]        px_q, px_d;
    logic signed [5:0]        py_q, py_d;
    logic [3:0][3:0]          shape_q, shape_d;
    logic [yw_lp-1:0]         row_q, row_d;
    logic [2:0]               lines_q, lines_d;
    logic [3:0][3:0]          score_q, score_d;
    logic                     done_q, done_d;

    logic                     handshake;
    logic                     query_in_range;
    logic                     row_full;
    logic                     mm_hit;
    logic                     coll_hit;

    // Digit [0] is the most significant; carry ripples from [3] upwards.
    function automatic logic [3:0][3:0] bcd_inc(input logic [3:0][3:0] s);
        logic [3:0][3:0] r;
        logic            carry;
        r     = s;
        carry = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (carry) begin
                if (s[i] == 4'd9) begin
                    r[i] = 4'd0;
                end else begin
                    r[i]  = s[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign busy_o         = (state_q != IDLE);
    assign commit_ready_o = (state_q == IDLE) && !clear_i;
    assign handshake      = commit_v_i && commit_ready_o;
    assign done_o         = done_q;
    assign lines_o        = lines_q;
    assign score_o        = score_q;

    assign query_in_range = (32'(scene_x_i) < scene_width_p) && (32'(scene_y_i) < scene_height_p);
    assign cm_o           = query_in_range && map_q[scene_y_i][scene_x_i];
    assign mm_o           = piece_v_i && !busy_o && query_in_range && mm_hit;
    assign collide_o      = piece_v_i && coll_hit;
    assign row_full       = &map_q[row_q];

    // Live-piece lookups: rows above the board (y < 0) are legal spawn space.
    always_comb begin
        int cx;
        int cy;
        mm_hit   = 1'b0;
        coll_hit = 1'b0;
        cx       = 0;
        cy       = 0;
        for (int dx = 0; dx < 4; dx++) begin
            for (int dy = 0; dy < 4; dy++) begin
                cx = int'(piece_x_i) + dx;
                cy = int'(piece_y_i) + dy;
                if (piece_shape_i[dx][dy]) begin
                    if (cx == int'(scene_x_i) && cy == int'(scene_y_i)) begin
                        mm_hit = 1'b1;
                    end
                    if (cx < 0 || cx >= scene_width_p || cy >= scene_height_p) begin
                        coll_hit = 1'b1;
                    end else if (cy >= 0 && map_q[cy[yw_lp-1:0]][cx[xw_lp-1:0]]) begin
                        coll_hit = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        int cx;
        int cy;
        state_d = state_q;
        map_d   = map_q;
        px_d    = px_q;
        py_d    = py_q;
        shape_d = shape_q;
        row_d   = row_q;
        lines_d = lines_q;
        score_d = score_q;
        done_d  = 1'b0;
        cx      = 0;
        cy      = 0;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    px_d    = piece_x_i;
                    py_d    = piece_y_i;
                    shape_d = piece_shape_i;
                    lines_d = '0;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                for (int dx = 0; dx < 4; dx++) begin
                    for (int dy = 0; dy < 4; dy++) begin
                        cx = int'(px_q) + dx;
                        cy = int'(py_q) + dy;
                        if (shape_q[dx][dy] && cx >= 0 && cx < scene_width_p &&
                            cy >= 0 && cy < scene_height_p) begin
                            map_d[cy[yw_lp-1:0]][cx[xw_lp-1:0]] = 1'b1;
                        end
                    end
                end
                row_d   = yw_lp'(scene_height_p - 1);
                state_d = SCAN;
            end
            SCAN: begin
                if (row_full) begin
                    state_d = SHIFT;
                end else if (row_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    row_d = row_q - yw_lp'(1);
                end
            end
            SHIFT: begin
                // Row index is kept so the row that dropped in gets rescanned.
                for (int r = 1; r < scene_height_p; r++) begin
                    if (r <= int'(row_q)) begin
                        map_d[r] = map_q[r-1];
                    end
                end
                map_d[0] = '0;
                lines_d  = lines_q + 3'd1;
                if (score_q != {4{4'd9}}) begin
                    score_d = bcd_inc(score_q);
                end
                state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            for (int r = 0; r < scene_height_p; r++) begin
                map_d[r] = '0;
            end
            score_d = '0;
            lines_d = '0;
            done_d  = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            for (int r = 0; r < scene_height_p; r++) begin
                map_q[r] <= '0;
            end
            px_q    <= '0;
            py_q    <= '0;
            shape_q <= '0;
            row_q   <= '0;
            lines_q <= '0;
            score_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            px_q    <= px_d;
            py_q    <= py_d;
            shape_q <= shape_d;
            row_q   <= row_d;
            lines_q <= lines_d;
            score_q <= score_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_tetris_board_store.sv
// Bench for tetris_board_store: directed commits with a done_o-driven scoreboard,
// plus a 4x4 instance used to run the score up to saturation.
module tb_tetris_board_store;

    localparam int W = 10;
    localparam int H = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset;
    logic [3:0]            sx;
    logic [4:0]            sy;
    logic                  cm, mm, pv, collide, cv, cready, clr, busy, done;
    logic signed [5:0]     px, py;
    logic [3:0][3:0]       shape;
    logic [2:0]            lines;
    logic [3:0][3:0]       score;

    logic [1:0]            sx2, sy2;
    logic                  cm2, mm2, pv2, collide2, cv2, cready2, clr2, busy2, done2;
    logic signed [5:0]     px2, py2;
    logic [3:0][3:0]       shape2;
    logic [2:0]            lines2;
    logic [3:0][3:0]       score2;

    tetris_board_store #(.scene_width_p(W), .scene_height_p(H)) dut (
        .clk_i(clk), .reset_i(reset), .scene_x_i(sx), .scene_y_i(sy),
        .cm_o(cm), .mm_o(mm), .piece_v_i(pv), .piece_x_i(px), .piece_y_i(py),
        .piece_shape_i(shape), .collide_o(collide), .commit_v_i(cv),
        .commit_ready_o(cready), .clear_i(clr), .busy_o(busy), .done_o(done),
        .lines_o(lines), .score_o(score)
    );

    tetris_board_store #(.scene_width_p(4), .scene_height_p(4)) dut2 (
        .clk_i(clk), .reset_i(reset), .scene_x_i(sx2), .scene_y_i(sy2),
        .cm_o(cm2), .mm_o(mm2), .piece_v_i(pv2), .piece_x_i(px2), .piece_y_i(py2),
        .piece_shape_i(shape2), .collide_o(collide2), .commit_v_i(cv2),
        .commit_ready_o(cready2), .clear_i(clr2), .busy_o(busy2), .done_o(done2),
        .lines_o(lines2), .score_o(score2)
    );

    typedef struct {
        logic [2:0]  lines;
        logic [15:0] score;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   done_cnt1   = 0;
    int   done_cnt2   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Packed layout matches score_o: digit [0] (bits 3:0) is the thousands digit.
    function automatic logic [15:0] to_bcd(input int v);
        logic [3:0][3:0] d;
        d[0] = 4'((v / 1000) % 10);
        d[1] = 4'((v / 100) % 10);
        d[2] = 4'((v / 10) % 10);
        d[3] = 4'(v % 10);
        return d;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt1++;
                if (q1.size() == 0) begin
                    check("dut1_unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = q1.pop_front();
                    check("dut1_done_cycle", 32'(cyc), 32'(e.due));
                    check("dut1_lines", 32'(lines), 32'(e.lines));
                    check("dut1_score", 32'(score), 32'(e.score));
                end
            end
            if (done2) begin
                done_cnt2++;
                if (q2.size() == 0) begin
                    check("dut2_unexpected_done", 32'(done2), 32'(0));
                end else begin
                    e = q2.pop_front();
                    check("dut2_done_cycle", 32'(cyc), 32'(e.due));
                    check("dut2_lines", 32'(lines2), 32'(e.lines));
                    check("dut2_score", 32'(score2), 32'(e.score));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic commit1(input int x, input int y, input logic [15:0] shp,
                           input int nl, input int sc, input int lat, input bit expect_done);
        px = 6'(x); py = 6'(y); shape = shp; pv = 1'b1; cv = 1'b1;
        #1;
        check("dut1_ready_at_commit", 32'(cready), 32'(1));
        if (expect_done) q1.push_back('{lines: 3'(nl), score: to_bcd(sc), due: cyc + lat});
        @(posedge clk);
        #1 cv = 1'b0; pv = 1'b0;
    endtask

    task automatic wait_done1(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check("dut1_done_seen", 32'(done), 32'(1));
    endtask

    task automatic commit2(input logic [15:0] shp, input int nl, input int sc, input int lat);
        px2 = 6'(0); py2 = 6'(0); shape2 = shp; pv2 = 1'b1; cv2 = 1'b1;
        #1;
        if (!cready2) check("dut2_ready_at_commit", 32'(cready2), 32'(1));
        q2.push_back('{lines: 3'(nl), score: to_bcd(sc), due: cyc + lat});
        @(posedge clk);
        #1 cv2 = 1'b0; pv2 = 1'b0;
    endtask

    task automatic wait_done2(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done2 && n < budget);
        if (!done2) check("dut2_done_seen", 32'(done2), 32'(1));
    endtask

    task automatic check_row(input int y, input logic [9:0] exp);
        logic [9:0] got;
        got = '0;
        for (int x = 0; x < W; x++) begin
            @(negedge clk);
            sx = 4'(x); sy = 5'(y);
            #1 got[x] = cm;
        end
        check($sformatf("row%0d", y), 32'(got), 32'(exp));
    endtask

    task automatic coll(input string nm, input int x, input int y, input logic [15:0] shp,
                        input logic v, input logic exp);
        @(negedge clk);
        pv = v; px = 6'(x); py = 6'(y); shape = shp;
        #1 check(nm, 32'(collide), 32'(exp));
    endtask

    initial begin
        int model;
        int saved;
        reset = 1'b1; clr = 1'b0; cv = 1'b0; pv = 1'b0; px = '0; py = '0; shape = '0;
        sx = '0; sy = '0;
        clr2 = 1'b0; cv2 = 1'b0; pv2 = 1'b0; px2 = '0; py2 = '0; shape2 = '0;
        sx2 = '0; sy2 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and empty board
        #1;
        check("rst_score", 32'(score), 32'(0));
        check("rst_lines", 32'(lines), 32'(0));
        check("rst_ready", 32'(cready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        for (int y = 0; y < H; y++) check_row(y, 10'h000);

        // Collision bounds with the O-piece
        coll("coll_8_18", 8, 18, 16'h0033, 1'b1, 1'b0);
        coll("coll_9_18", 9, 18, 16'h0033, 1'b1, 1'b1);
        coll("coll_8_19", 8, 19, 16'h0033, 1'b1, 1'b1);
        coll("coll_m1_0", -1, 0, 16'h0033, 1'b1, 1'b1);
        coll("coll_3_m2", 3, -2, 16'h0033, 1'b1, 1'b0);
        coll("coll_pv0", 9, 18, 16'h0033, 1'b0, 1'b0);

        // Moving-cell query, including a piece cell that lies past the right edge
        @(negedge clk);
        pv = 1'b1; px = 6'(8); py = 6'(18); shape = 16'h0033; sx = 4'(9); sy = 5'(19);
        #1 check("mm_hit", 32'(mm), 32'(1));
        sx = 4'(7);
        #1 check("mm_miss", 32'(mm), 32'(0));
        px = 6'(9); py = 6'(0); sx = 4'(10); sy = 5'(0);
        #1 check("mm_oob_query", 32'(mm), 32'(0));
        pv = 1'b0;

        // Single-row clear
        @(negedge clk);
        commit1(0, 19, 16'h1111, 0, 0, 22, 1'b1); wait_done1(40);
        commit1(4, 19, 16'h1111, 0, 0, 22, 1'b1); wait_done1(40);
        commit1(8, 19, 16'h0001, 0, 0, 22, 1'b1); wait_done1(40);
        check_row(19, 10'h1FF);
        @(negedge clk);
        commit1(9, 16, 16'h000F, 1, 1, 24, 1'b1); wait_done1(40);
        check_row(19, 10'h200);
        check_row(18, 10'h200);
        check_row(17, 10'h200);
        check_row(16, 10'h000);

        // Restart board
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("clear_score", 32'(score), 32'(0));
        check("clear_lines", 32'(lines), 32'(0));
        check_row(19, 10'h000);

        // Four-row clear, with busy-time masking and an ignored commit
        @(negedge clk);
        commit1(1, 16, 16'hFFFF, 0, 0, 22, 1'b1); wait_done1(40);
        commit1(5, 16, 16'hFFFF, 0, 0, 22, 1'b1); wait_done1(40);
        commit1(9, 16, 16'h000F, 0, 0, 22, 1'b1); wait_done1(40);
        check_row(19, 10'h3FE);
        check_row(16, 10'h3FE);
        @(negedge clk);
        pv = 1'b1; px = 6'(0); py = 6'(16); shape = 16'h000F; sx = 4'(0); sy = 5'(17);
        #1 check("mm_idle_visible", 32'(mm), 32'(1));
        commit1(0, 16, 16'h000F, 4, 4, 30, 1'b1);
        @(negedge clk);
        pv = 1'b1; px = 6'(0); py = 6'(16); shape = 16'h000F; sx = 4'(0); sy = 5'(17); cv = 1'b1;
        #1;
        check("busy_high", 32'(busy), 32'(1));
        check("busy_ready_low", 32'(cready), 32'(0));
        check("busy_mm_masked", 32'(mm), 32'(0));
        repeat (4) @(negedge clk);
        cv = 1'b0; pv = 1'b0;
        wait_done1(40);
        repeat (3) @(negedge clk);
        check("ignored_commit_idle", 32'(busy), 32'(0));
        for (int y = 0; y < H; y++) check_row(y, 10'h000);

        // Abort mid-SCAN
        @(negedge clk);
        commit1(0, 19, 16'h0001, 0, 0, 22, 1'b0);
        repeat (5) @(negedge clk);
        check("abort_in_scan", 32'(busy), 32'(1));
        saved = done_cnt1;
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(busy), 32'(0));
        check("abort_score", 32'(score), 32'(0));
        check("abort_lines", 32'(lines), 32'(0));
        check_row(19, 10'h000);
        repeat (30) @(negedge clk);
        check("abort_no_done", 32'(done_cnt1), 32'(saved));

        // Score saturation on the 4x4 board
        model = 0;
        @(negedge clk);
        for (int i = 0; i < 2499; i++) begin
            model = (model + 4 > 9999) ? 9999 : model + 4;
            commit2(16'hFFFF, 4, model, 14);
            wait_done2(20);
        end
        check("sat_9996", 32'(score2), 32'(to_bcd(9996)));
        commit2(16'hCCCC, 2, 9998, 10); wait_done2(20);
        commit2(16'hEEEE, 3, 9999, 12); wait_done2(20);
        check("sat_lines", 32'(lines2), 32'(3));
        check("sat_score", 32'(score2), 32'(to_bcd(9999)));
        commit2(16'hFFFF, 4, 9999, 14); wait_done2(20);
        @(negedge clk);
        pv2 = 1'b1; px2 = 6'(0); py2 = 6'(0); shape2 = 16'hFFFF; sx2 = 2'(3); sy2 = 2'(3);
        #1;
        check("dut2_collide_clear", 32'(collide2), 32'(0));
        check("dut2_mm", 32'(mm2), 32'(1));
        check("dut2_cm_empty", 32'(cm2), 32'(0));
        px2 = 6'(1);
        #1 check("dut2_collide_right", 32'(collide2), 32'(1));
        pv2 = 1'b0;

        repeat (3) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'(0));
        check("q2_drained", 32'(q2.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
